// File: rtl/bridge_pkg.sv
// bridge_pkg: shared definitions for the I2C-to-UART bridge.
// Contents: state_t (UART transmitter FSM encoding) and level_w(), the width of a
// FIFO occupancy count able to hold 0..depth.
package bridge_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/bridge_sync_fifo.sv
// bridge_sync_fifo: single-clock FIFO with full/empty flags and occupancy count.
// Ports: clk, reset (async active-low), i_wr/i_wdata (write), i_rd (pop),
//        o_rdata (head word, valid while !o_empty), o_full, o_empty, o_level (0..DEPTH).
// A write is accepted when not full, or when a pop happens on the same edge.
module bridge_sync_fifo import bridge_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wr,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic                      i_rd,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [level_w(DEPTH)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_wr_en;
  logic              w_rd_en;
  assign o_empty = r_level == '0;
  assign o_full  = r_level == LW'(DEPTH);
  assign w_rd_en = i_rd && !o_empty;
  assign w_wr_en = i_wr && (!o_full || w_rd_en);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  always_ff @(posedge clk)
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_wr_en) - LW'(w_rd_en);
    end
endmodule

// File: rtl/i2c_uart_bridge_p.sv
// i2c_uart_bridge_p: buffers words from an I2C slave receiver and sends them on a UART line.
// Ports: clk, reset (async active-low), rx_data/rx_valid (write strobe from I2C side),
//        clr_ovf (sync clear of overflow), TX (serial out, idle high), tx_busy (frame on line),
//        tx_done (pulse during the final stop-bit cycle), fifo_level (0..DEPTH),
//        overflow (sticky: a write was dropped while full).
// Optional macro PARITY_EN: adds parameter PARITY_ODD and a parity bit after the data bits.
module i2c_uart_bridge_p import bridge_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
`ifdef PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_valid,
  input  logic                      clr_ovf,
  output logic                      TX,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic [level_w(DEPTH)-1:0] fifo_level,
  output logic                      overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  state_t            r_state;
  logic [BW-1:0]     r_baud;
  logic [CW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
`ifdef PARITY_EN
  logic              r_par;
`endif
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_rdata;
  // Pop depends only on registered state and level, so a word is never bypassed.
  assign w_pop     = r_state == ST_IDLE && !w_empty;
  assign w_bit_end = r_baud == BAUD_LAST;
  assign TX        = r_tx;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;
  assign overflow  = r_ovf;
  bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (rx_valid),
    .i_wdata (rx_data),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );
  // A dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ovf <= 1'b0;
    else if (rx_valid && w_full && !w_pop) r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_baud <= (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud + BW'(1);
      case (r_state)
        ST_IDLE:
          if (w_pop) begin
            r_state <= ST_START;
            r_shift <= w_rdata;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_bit   <= '0;
`ifdef PARITY_EN
            r_par   <= ^w_rdata ^ PARITY_ODD;
`endif
          end
        ST_START:
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        // The shift register always presents the next bit at [1], LSB first.
        ST_DATA:
          if (w_bit_end) begin
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
`ifdef PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + CW'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        ST_PARITY:
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        // r_bit counts stop bits here; tx_done is raised one cycle early so it
        // is high exactly during the final stop-bit cycle.
        ST_STOP: begin
          if (r_bit == STOP_LAST && r_baud == BAUD_PRE) r_done <= 1'b1;
          if (w_bit_end) begin
            if (r_bit == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_bit   <= '0;
            end else r_bit <= r_bit + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: doc/i2c_uart_bridge_p.md
Name: i2c_uart_bridge_p

Overview:
Parametrised successor to the I2C-to-UART bridge top. It accepts bytes from the I2C slave receiver as a clk-synchronous valid strobe, buffers them in an internal FIFO, and serialises them on a UART transmitter.
- Everything runs on one system clock (not SCL).
- Baud rate, data width, FIFO depth and stop bits are configurable.
- An overflow status flag is provided.

Parameters:
DATA_W, 8, width of each byte/word carried and UART data bits (5..9)
DEPTH, 16, FIFO entries; power of two, >=2
CLKS_PER_BIT, 868, clk cycles per UART bit (>=2)
STOP_BITS, 1, UART stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  DATA_W  word from I2C receiver, valid with rx_valid
rx_valid  input  1  one-cycle write strobe (I2C ack already synchronised to clk)
clr_ovf  input  1  synchronous clear of the overflow flag
TX  output  1  UART serial line, idle high
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse at the end of the last stop bit
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (reset low, asynchronous) forces:
  - TX=1, tx_busy=0, tx_done=0, fifo_level=0, overflow=0.
  - FSM to IDLE; FIFO pointers to 0.
- Reset mid-frame aborts the frame immediately and discards FIFO contents.
- FIFO writes:
  - On rx_valid while not full: store rx_data, level+1.
  - On rx_valid while full: drop the word and set overflow.
  - overflow clears only on clr_ovf or reset. clr_ovf and a dropped write in the same cycle leave overflow=1.
- FIFO read/pop:
  - Pop only when the FSM is in IDLE and the FIFO is not empty. No bypass: a word written at edge k is popped no earlier than edge k+1.
  - Simultaneous write and pop: level unchanged, and the write is accepted even if level==DEPTH at that edge.
- Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- Latency: with the FIFO empty and FSM idle, rx_valid sampled at edge k puts TX low (start bit) from edge k+1.
- FSM states:
  - IDLE -> START on pop. The popped word is loaded into the shift register, TX=0 and tx_busy=1.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA shifts LSB first, one bit per CLKS_PER_BIT cycles, for DATA_W bits.
  - DATA -> PARITY (only if PARITY_EN is defined) or STOP.
  - STOP holds TX=1 for STOP_BITS*CLKS_PER_BIT cycles. On its final cycle it pulses tx_done and returns to IDLE.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, IDLE pops on the next edge. This gives exactly one idle cycle between frames.
- The bit counter and baud counter are registered. The baud counter width is $clog2(CLKS_PER_BIT).
- TX is driven from a register, so it is glitch-free.

Optional Feature:
- Macro PARITY_EN.
  - Defined: adds parameter PARITY_ODD (default 0). A PARITY state follows DATA for one bit time and transmits the XOR of the data bits (even parity), inverted when PARITY_ODD=1. Frame length is 1+DATA_W+1+STOP_BITS bits.
  - Not defined: no PARITY state; frame length is 1+DATA_W+STOP_BITS bits.

Decomposition:
- Shared package bridge_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP);
  - the width helper for fifo_level.
- One sub-module, bridge_sync_fifo (DATA_W, DEPTH): single-clock FIFO with full/empty/level. It is instantiated once. The UART FSM stays in the top.

Test Plan:
All tests use DATA_W=8, DEPTH=4, CLKS_PER_BIT=4, STOP_BITS=1.
- Single byte: rx_valid with 0xA5 -> TX low one edge later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then a stop bit. tx_done pulses 40 cycles after the start bit begins; fifo_level returns to 0.
- Burst: 0x01,0x02,0x03 on consecutive cycles -> fifo_level peaks at 2. Three frames go out in order, each separated by exactly one idle cycle.
- Overflow: 6 writes on consecutive cycles while the first frame is sending -> words 1..5 accepted (one popped), the 6th dropped and overflow=1. clr_ovf then drops overflow to 0.
- Reset mid-frame: assert reset 10 cycles into a frame -> TX=1 and tx_busy=0 immediately (asynchronous), fifo_level=0. No frame appears after release until a new write.
- PARITY_EN with PARITY_ODD=0: send 0x07 -> parity bit 1 after the data bits; frame is 11 bits, 44 cycles.
- STOP_BITS=2: send 0xFF -> TX held high for 8 cycles after the data bits before tx_done.
